// File: rtl/oclib_pkg.sv
// Shared AXI-Lite types, response codes and helpers for the oclib register blocks.
package oclib_pkg;

  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic        rready;
  } axil_32_s;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } axil_32_fb_s;

  localparam logic [1:0] AxilRespOkay   = 2'b00;
  localparam logic [1:0] AxilRespSlvErr = 2'b10;

  typedef enum logic [1:0] {
    WrIdle   = 2'd0,
    WrCommit = 2'd1,
    WrResp   = 2'd2
  } axil_wr_state_e;

  // Width of a register index; a single-register file still needs a 1-bit index.
  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oclib_axil_regfile_decode.sv
// Byte address to register index / range / read-only decoder, shared by write and read paths.
module oclib_axil_regfile_decode
  import oclib_pkg::*;
#(
  parameter int                   NumRegs      = 8,
  parameter logic [NumRegs-1:0]   ReadOnlyMask = '0,
  parameter int                   IdxW         = idx_width(NumRegs)
) (
  input  logic [31:0]     addr,
  output logic [IdxW-1:0] idx,
  output logic            in_range,
  output logic            read_only
);

  localparam int Log2 = $clog2(NumRegs);

  logic [31:0] word;

  // addr[1:0] is dropped by the shift; everything above the index field must be zero.
  assign word = addr >> 2;

  always_comb begin
    idx       = (NumRegs == 1) ? '0 : word[IdxW-1:0];
    in_range  = ((word >> Log2) == 32'd0);
    read_only = in_range & ReadOnlyMask[idx];
  end

endmodule

// File: rtl/oclib_axil_regfile.sv
// AXI-Lite register file: NumRegs 32-bit R/W or read-only registers with OKAY/SLVERR responses.
// Optional OCLIB_AXIL_REGFILE_WRITE_PULSE_EN adds a per-register one-cycle writePulse output.
module oclib_axil_regfile
  import oclib_pkg::*;
#(
  parameter type                   AxilType     = oclib_pkg::axil_32_s,
  parameter type                   AxilFbType   = oclib_pkg::axil_32_fb_s,
  parameter int                    NumRegs      = 8,
  parameter logic [NumRegs-1:0]    ReadOnlyMask = '0,
  parameter logic [NumRegs*32-1:0] ResetValues  = '0
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  AxilType                 axil,
  output AxilFbType               axilFb,
  output logic [NumRegs*32-1:0]   regOut,
`ifdef OCLIB_AXIL_REGFILE_WRITE_PULSE_EN
  output logic [NumRegs-1:0]      writePulse,
`endif
  input  logic [NumRegs*32-1:0]   regIn
);

  localparam int   IdxW   = idx_width(NumRegs);
  localparam logic RdIdle = 1'b0;
  localparam logic RdResp = 1'b1;

  axil_wr_state_e        wr_state;
  logic                  aw_got, w_got, awready_q, wready_q;
  logic [31:0]           aw_addr, w_data;
  logic [3:0]            w_strb;
  logic [1:0]            bresp_q;
  logic [NumRegs*32-1:0] regs_q;

  logic                  aw_hs, w_hs, commit, wr_ok;
  logic [31:0]           cur_addr, cur_data;
  logic [3:0]            cur_strb;
  logic [IdxW-1:0]       wr_idx;
  logic                  wr_in_range, wr_ro;

  logic                  rd_state, arready_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_hs;
  logic [IdxW-1:0]       rd_idx;
  logic                  rd_in_range, rd_ro;

  assign aw_hs = axil.awvalid & awready_q;
  assign w_hs  = axil.wvalid & wready_q;

  // The half arriving this cycle is used directly so a same-cycle AW+W commits immediately.
  assign cur_addr = aw_got ? aw_addr : axil.awaddr;
  assign cur_data = w_got ? w_data : axil.wdata;
  assign cur_strb = w_got ? w_strb : axil.wstrb;
  assign commit   = (wr_state == WrIdle) & (aw_got | aw_hs) & (w_got | w_hs);
  assign wr_ok    = wr_in_range & ~wr_ro;

  oclib_axil_regfile_decode #(
    .NumRegs(NumRegs), .ReadOnlyMask(ReadOnlyMask), .IdxW(IdxW)
  ) u_wr_decode (
    .addr(cur_addr), .idx(wr_idx), .in_range(wr_in_range), .read_only(wr_ro)
  );

  oclib_axil_regfile_decode #(
    .NumRegs(NumRegs), .ReadOnlyMask(ReadOnlyMask), .IdxW(IdxW)
  ) u_rd_decode (
    .addr(axil.araddr), .idx(rd_idx), .in_range(rd_in_range), .read_only(rd_ro)
  );

  always_ff @(posedge clock) begin
    if (aw_hs) aw_addr <= axil.awaddr;
    if (w_hs) begin
      w_data <= axil.wdata;
      w_strb <= axil.wstrb;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_state  <= WrIdle;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= AxilRespOkay;
    end else begin
      case (wr_state)
        WrIdle: begin
          if (commit) begin
            wr_state  <= WrCommit;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bresp_q   <= wr_ok ? AxilRespOkay : AxilRespSlvErr;
          end else begin
            aw_got    <= aw_got | aw_hs;
            w_got     <= w_got | w_hs;
            awready_q <= ~(aw_got | aw_hs);
            wready_q  <= ~(w_got | w_hs);
          end
        end
        WrCommit, WrResp: begin
          if (axil.bready) begin
            wr_state  <= WrIdle;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end else begin
            wr_state  <= WrResp;
          end
        end
        default: wr_state <= WrIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      regs_q <= ResetValues;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_strb[b]) regs_q[32*int'(wr_idx) + 8*b +: 8] <= cur_data[8*b +: 8];
      end
    end
  end

  assign regOut = regs_q;

`ifdef OCLIB_AXIL_REGFILE_WRITE_PULSE_EN
  logic [NumRegs-1:0] wr_onehot;

  always_comb begin
    wr_onehot         = '0;
    wr_onehot[wr_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) writePulse <= '0;
    else         writePulse <= (commit && wr_ok) ? wr_onehot : '0;
  end
`endif

  assign ar_hs = axil.arvalid & arready_q;

  // Read data is captured before any same-cycle commit lands, so it returns the old value.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rd_state  <= RdIdle;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AxilRespOkay;
    end else begin
      case (rd_state)
        RdIdle: begin
          if (ar_hs) begin
            rd_state  <= RdResp;
            arready_q <= 1'b0;
            rresp_q   <= rd_in_range ? AxilRespOkay : AxilRespSlvErr;
            if (!rd_in_range) rdata_q <= '0;
            else if (rd_ro)   rdata_q <= regIn[32*int'(rd_idx) +: 32];
            else              rdata_q <= regs_q[32*int'(rd_idx) +: 32];
          end else begin
            arready_q <= 1'b1;
          end
        end
        default: begin
          if (axil.rready) begin
            rd_state  <= RdIdle;
            arready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    axilFb         = '0;
    axilFb.awready = awready_q;
    axilFb.wready  = wready_q;
    axilFb.bvalid  = (wr_state != WrIdle);
    axilFb.bresp   = bresp_q;
    axilFb.arready = arready_q;
    axilFb.rvalid  = (rd_state == RdResp);
    axilFb.rdata   = rdata_q;
    axilFb.rresp   = rresp_q;
  end

endmodule
